// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side signal bundle for mem_port_arbiter.
//   Fetch side : i_req, i_addr -> i_rdata, i_ack
//   Data side  : d_req, d_we, d_addr, d_wdata -> d_rdata, d_ack
//   Memory side: m_req, m_we, m_addr, m_wdata -> m_rdata, m_ready
// Modports: master = the arbiter itself, slave = core plus memory environment.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
  parameter int unsigned n  = 32,
  parameter int unsigned AW = 32
) ();
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [n-1:0]  i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [n-1:0]  d_wdata;
  logic [n-1:0]  d_rdata;
  logic          d_ack;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [n-1:0]  m_wdata;
  logic [n-1:0]  m_rdata;
  logic          m_ready;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    output i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
    input  i_rdata, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One transaction outstanding at a time; the memory command is registered and held
// until m_ready, then read data is captured and a one-cycle ack goes to the winner.
// Ports:
//   CLK   - clock, rising edge
//   RESET - asynchronous active-high reset
//   bus   - mem_port_arbiter_if.master (fetch, data and memory handshakes)
//   busy  - high whenever a grant is in progress
// Build option: define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
// requests; otherwise the data side always wins.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned n  = 32,
  parameter int unsigned AW = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  mem_port_arbiter_if.master  bus,
  output logic                busy
);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e        state_q;
  logic          m_req_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [n-1:0]  m_wdata_q;
  logic [n-1:0]  i_rdata_q;
  logic [n-1:0]  d_rdata_q;
  logic          i_ack_q;
  logic          d_ack_q;
  logic          busy_q;
  logic          grant_d;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d_q;  // 0 = fetch side won last, 1 = data side

  // On a tie the side that did not win last time gets the port.
  always_comb begin
    grant_d = bus.d_req && (!bus.i_req || !last_grant_d_q);
  end
`else
  always_comb begin
    grant_d = bus.d_req;
  end
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_d_q <= 1'b0;
`endif
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // m_ready is deliberately ignored here.
          if (bus.i_req || bus.d_req) begin
            m_req_q <= 1'b1;
            busy_q  <= 1'b1;
            if (grant_d) begin
              state_q   <= StGntD;
              m_we_q    <= bus.d_we;
              m_addr_q  <= bus.d_addr;
              m_wdata_q <= bus.d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
              last_grant_d_q <= 1'b1;
`endif
            end else begin
              state_q  <= StGntI;
              m_we_q   <= 1'b0;
              m_addr_q <= bus.i_addr;
`ifdef ARB_ROUND_ROBIN_EN
              last_grant_d_q <= 1'b0;
`endif
            end
          end
        end
        StGntI: begin
          if (bus.m_ready) begin
            state_q   <= StIdle;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            busy_q    <= 1'b0;
            i_rdata_q <= bus.m_rdata;
            i_ack_q   <= 1'b1;
          end
        end
        StGntD: begin
          if (bus.m_ready) begin
            state_q <= StIdle;
            m_req_q <= 1'b0;
            m_we_q  <= 1'b0;
            busy_q  <= 1'b0;
            // Stores leave the previous load data in place.
            if (!m_we_q) begin
              d_rdata_q <= bus.m_rdata;
            end
            d_ack_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          m_req_q <= 1'b0;
          m_we_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_addr  = m_addr_q;
  assign bus.m_wdata = m_wdata_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_ack   = i_ack_q;
  assign bus.d_ack   = d_ack_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic busy;

  mem_port_arbiter_if #(.n(32), .AW(32)) bus ();

  mem_port_arbiter #(.n(32), .AW(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    int          waits;
  } vec_t;
  vec_t vecs[6];

  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: every ack pops the oldest expected transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      chk("ack_exclusive", {31'd0, bus.i_ack & bus.d_ack}, 32'd0);
      if (bus.i_ack || bus.d_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("ack_side", {31'd0, bus.d_ack}, {31'd0, e.is_d});
          chk("ack_rdata", e.is_d ? bus.d_rdata : bus.i_rdata, e.rdata);
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_m_req"}, {31'd0, bus.m_req}, 32'd0);
    chk({tag, "_m_we"}, {31'd0, bus.m_we}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_i_ack"}, {31'd0, bus.i_ack}, 32'd0);
    chk({tag, "_d_ack"}, {31'd0, bus.d_ack}, 32'd0);
    chk({tag, "_m_addr"}, bus.m_addr, 32'd0);
    chk({tag, "_m_wdata"}, bus.m_wdata, 32'd0);
    chk({tag, "_i_rdata"}, bus.i_rdata, 32'd0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 32'd0);
  endtask

  task automatic run_txn(input vec_t v);
    exp_t e;
    bus.m_ready = 1'b0;
    if (v.is_d) begin
      bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = v.addr;
    end
    e.is_d = v.is_d;
    if (!v.is_d) begin
      exp_i_rdata = v.mdata;
      e.rdata = v.mdata;
    end else if (!v.we) begin
      exp_d_rdata = v.mdata;
      e.rdata = v.mdata;
    end else begin
      e.rdata = exp_d_rdata;
    end
    sb.push_back(e);
    tick();  // E0: grant
    chk("grant_m_req", {31'd0, bus.m_req}, 32'd1);
    chk("grant_busy", {31'd0, busy}, 32'd1);
    chk("grant_m_addr", bus.m_addr, v.addr);
    chk("grant_m_we", {31'd0, bus.m_we}, {31'd0, v.we});
    if (v.we) chk("grant_m_wdata", bus.m_wdata, v.wdata);
    // Requester wiggles its inputs after grant; the command must not follow.
    bus.i_addr  = ~v.addr;
    bus.d_addr  = ~v.addr;
    bus.d_wdata = ~v.wdata;
    for (int k = 0; k < v.waits; k++) begin
      bus.m_ready = 1'b0;
      bus.m_rdata = 32'hFFFF_0000 ^ k;
      tick();
      chk("wait_m_req", {31'd0, bus.m_req}, 32'd1);
      chk("wait_m_addr", bus.m_addr, v.addr);
      if (v.we) chk("wait_m_wdata", bus.m_wdata, v.wdata);
      chk("wait_no_ack", {31'd0, bus.i_ack | bus.d_ack}, 32'd0);
    end
    bus.m_ready = 1'b1;
    bus.m_rdata = v.mdata;
    tick();  // E1: completion
    chk("done_ack", {31'd0, v.is_d ? bus.d_ack : bus.i_ack}, 32'd1);
    chk("done_m_req", {31'd0, bus.m_req}, 32'd0);
    chk("done_m_we", {31'd0, bus.m_we}, 32'd0);
    chk("done_busy", {31'd0, busy}, 32'd0);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'h0;
    tick();
    chk("ack_one_cycle", {31'd0, bus.i_ack | bus.d_ack}, 32'd0);
    chk("idle_m_req", {31'd0, bus.m_req}, 32'd0);
    chk("held_i_rdata", bus.i_rdata, exp_i_rdata);
    chk("held_d_rdata", bus.d_rdata, exp_d_rdata);
  endtask

  initial begin
    int acks;
    exp_t e;
    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'h00A00093, 0};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 3};
    vecs[2] = '{1'b1, 1'b1, 32'h8,   32'h12345678, 32'hBAD0BAD0, 1};
    vecs[3] = '{1'b0, 1'b0, 32'h44,  32'h0,        32'h13579BDF, 2};
    vecs[4] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'h0F0F0F0F, 0};
    vecs[5] = '{1'b1, 1'b1, 32'h10,  32'hCAFEF00D, 32'h55555555, 0};

    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.m_rdata = 0; bus.m_ready = 0;
    tick();
    tick();
    check_reset_state("reset");
    RESET = 1'b0;
    tick();

    foreach (vecs[i]) run_txn(vecs[i]);

    // Spurious m_ready while idle.
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'hA5A5A5A5;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("spur_m_req", {31'd0, bus.m_req}, 32'd0);
      chk("spur_busy", {31'd0, busy}, 32'd0);
      chk("spur_i_rdata", bus.i_rdata, exp_i_rdata);
      chk("spur_d_rdata", bus.d_rdata, exp_d_rdata);
    end
    bus.m_ready = 1'b0;

    // Reset during the second wait cycle of a load.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h300;
    tick();
    chk("abort_grant", {31'd0, bus.m_req}, 32'd1);
    tick();
    #2;
    RESET = 1'b1;
    #1;
    check_reset_state("async_reset");
    bus.d_req = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    tick();
    chk("abort_no_ack", {31'd0, bus.d_ack}, 32'd0);
    RESET = 1'b0;
    tick();
    run_txn('{1'b0, 1'b0, 32'h80, 32'h0, 32'h00112233, 1});

    // Contention from a fresh reset (last grant = fetch side).
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    tick();
    bus.i_req = 1'b1; bus.i_addr = 32'h500;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600;
    bus.m_ready = 1'b1; bus.m_rdata = 32'hC0FFEE00;
    for (int g = 0; g < 4; g++) begin
      e.rdata = 32'hC0FFEE00;
`ifdef ARB_ROUND_ROBIN_EN
      e.is_d = (g % 2 == 0);
`else
      e.is_d = 1'b1;
`endif
      sb.push_back(e);
    end
    acks = 0;
    for (int c = 0; c < 20 && acks < 4; c++) begin
      tick();
      if (bus.i_ack || bus.d_ack) acks++;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.m_ready = 1'b0;
    chk("contention_acks", acks, 32'd4);
    tick();
    tick();
    tick();
    chk("contention_idle", {31'd0, bus.m_req}, 32'd0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
